// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: in-order decoupling FIFO between the IFU and the IDU.
// Holds {pc, inst} pairs in a circular buffer. Flush discards every buffered entry on a redirect.
// Optional build macro IFQ_BYPASS_EN adds a 0-cycle path from in_* to out_* when the queue is empty.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_inst [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;
    logic byp_take;
    logic wr_en;
    logic rd_adv;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Occupancy flags: the wrap bit distinguishes full from empty when the indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

`ifdef IFQ_BYPASS_EN
    // Empty queue forwards the IFU entry straight through unless a redirect is in progress
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = ~full;
    assign out_valid = ~empty | bypass;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign byp_take = bypass & out_ready;
    // A bypassed entry taken by the IDU never enters storage; flush drops stale-path pushes
    assign wr_en    = push & ~flush & ~byp_take;
    assign rd_adv   = pop & ~empty & ~flush;

    // Head entry read; zero while nothing is available
    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else if (!empty) begin
            out_pc   = mem_pc[rd_idx];
            out_inst = mem_inst[rd_idx];
        end
    end

    // Pointer update: flush snaps the read pointer onto the write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_idx]   <= in_pc;
            mem_inst[wr_idx] <= in_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [CW-1:0]   count;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];
    logic [XLEN-1:0] next_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model
    task automatic cyc(input logic iv, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                       input logic ordy, input logic fl);
        logic            byp;
        logic            can_push;
        logic            exp_valid;
        logic [XLEN-1:0] exp_pc;
        logic [XLEN-1:0] exp_inst;
        int              sz;
        ent_t            e;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz = q.size();
`ifdef IFQ_BYPASS_EN
        byp = (sz == 0) && iv && !fl;
`else
        byp = 1'b0;
`endif
        exp_valid = (sz != 0) || byp;
        exp_pc    = '0;
        exp_inst  = '0;
        if (byp) begin
            exp_pc   = pc;
            exp_inst = inst;
        end else if (sz != 0) begin
            exp_pc   = q[0].pc;
            exp_inst = q[0].inst;
        end
        check("count",     64'(count),     64'(sz));
        check("in_ready",  64'(in_ready),  64'(sz < DEPTH));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("out_pc",    64'(out_pc),    64'(exp_pc));
        check("out_inst",  64'(out_inst),  64'(exp_inst));
        // Reference behaviour: flush empties, else pop head and append if not full beforehand
        if (fl) begin
            q.delete();
        end else if (!(byp && ordy)) begin
            can_push = iv && (sz < DEPTH);
            if (sz != 0 && ordy) void'(q.pop_front());
            if (can_push) begin
                e.pc   = pc;
                e.inst = inst;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, '0, '0, ordy, 1'b0);
    endtask

    task automatic push_one(input logic ordy);
        cyc(1'b1, next_pc, $urandom, ordy, 1'b0);
        next_pc = next_pc + 32'd4;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        next_pc = 32'h8000_0000;

        // Reset state, then fill to full with the IDU stalled and drain in order
        idle(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, next_pc, 32'h0000_1000 + next_pc, 1'b0, 1'b0);
            next_pc = next_pc + 32'd4;
        end
        idle(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Streaming with both sides ready; pointers wrap several times
        for (int i = 0; i < 20; i++) push_one(1'b1);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Flush with a concurrent push: the pushed entry must not appear
        for (int i = 0; i < 3; i++) push_one(1'b0);
        cyc(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Full queue: simultaneous pop and push attempt; push is rejected
        for (int i = 0; i < DEPTH; i++) push_one(1'b0);
        cyc(1'b1, 32'hBAD0_0000, 32'hBAD0_0001, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        // Asynchronous reset mid-stream with two entries buffered
        push_one(1'b0);
        push_one(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_count",     64'(count),     64'(0));
        check("async_in_ready",  64'(in_ready),  64'(1));
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1);

        // Empty queue with a valid entry and a ready IDU (same-cycle only with bypass)
        cyc(1'b1, next_pc, 32'h0000_0013, 1'b1, 1'b0);
        idle(1'b1);
        // Empty queue, IDU stalled: the entry must be stored
        cyc(1'b1, 32'h0000_4000, 32'h0000_0093, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), next_pc, $urandom,
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            next_pc = next_pc + 32'd4;
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
